// File: rtl/spi_stream_ctrl.sv
// Generic synchronous FIFO: head is readable combinationally, zero when empty.
// Push refused when full and pop refused when empty; simultaneous push/pop keeps occupancy.
module spi_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = wr_vld && !full;
    assign do_pop  = rd_rdy && !empty;
    assign rd_dat  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// SPI slave register-port sequencer exposing RX/TX byte streams; rx byte visible 3 cycles after RRDY.
// Core reads stall while the RX FIFO is full (overrun counted); tx_ready deasserts when TX FIFO full.
module spi_stream_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int STATUS_PERIOD = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        spi_select,
    output logic        read_n,
    output logic        write_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    input  logic        dataavailable,
    input  logic        readyfordata,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_ovf_cnt,
    output logic [7:0]  tx_ovf_cnt
);
    localparam logic [2:0]  ADDR_RX     = 3'd0;
    localparam logic [2:0]  ADDR_TX     = 3'd1;
    localparam logic [2:0]  ADDR_STATUS = 3'd2;
    localparam logic [2:0]  ADDR_CTRL   = 3'd3;
    localparam logic [15:0] POLL_LAST   = 16'(STATUS_PERIOD - 1);

    typedef enum logic [3:0] {
        INIT_W1, INIT_W2, IDLE, RD1, RD2, WR1, WR2,
        ST1, ST2, CLR1, CLR2, GAP
    } state_t;

    state_t      state;
    logic [15:0] poll_timer;
    logic        poll_due;
    logic        rx_full;
    logic        rx_empty;
    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_head;
    logic        roe;
    logic        toe;
    logic        unused_hi;

    assign poll_due  = (poll_timer == POLL_LAST);
    assign roe       = data_to_cpu[3];
    assign toe       = data_to_cpu[4];
    assign unused_hi = ^data_to_cpu[15:8];
    assign rx_valid  = !rx_empty;
    assign tx_ready  = !tx_full;

    spi_stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (state == RD2),
        .wr_dat  (data_to_cpu[7:0]),
        .rd_rdy  (rx_ready),
        .rd_dat  (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    spi_stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (tx_valid),
        .wr_dat  (tx_data),
        .rd_rdy  (state == WR2),
        .rd_dat  (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // Strobes are registered on entry to X1 so they are valid for exactly the X1 and X2 cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= INIT_W1;
            spi_select    <= 1'b0;
            read_n        <= 1'b1;
            write_n       <= 1'b1;
            mem_addr      <= 3'd0;
            data_from_cpu <= 16'h0000;
            poll_timer    <= 16'd0;
            rx_ovf_cnt    <= 8'd0;
            tx_ovf_cnt    <= 8'd0;
        end else begin
            if (!poll_due) poll_timer <= poll_timer + 16'd1;

            case (state)
                INIT_W1: begin
                    // Reset leaves the strobes idle, so the first free cycle launches the access.
                    if (!spi_select) begin
                        spi_select    <= 1'b1;
                        write_n       <= 1'b0;
                        mem_addr      <= ADDR_CTRL;
                        data_from_cpu <= 16'h0000;
                    end else begin
                        state <= INIT_W2;
                    end
                end
                INIT_W2: begin
                    state      <= GAP;
                    spi_select <= 1'b0;
                    write_n    <= 1'b1;
                end
                IDLE: begin
                    if (dataavailable && !rx_full) begin
                        state      <= RD1;
                        spi_select <= 1'b1;
                        read_n     <= 1'b0;
                        mem_addr   <= ADDR_RX;
                    end else if (readyfordata && !tx_empty) begin
                        state         <= WR1;
                        spi_select    <= 1'b1;
                        write_n       <= 1'b0;
                        mem_addr      <= ADDR_TX;
                        data_from_cpu <= {8'h00, tx_head};
                    end else if (poll_due) begin
                        state      <= ST1;
                        spi_select <= 1'b1;
                        read_n     <= 1'b0;
                        mem_addr   <= ADDR_STATUS;
                        poll_timer <= 16'd0;
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    state      <= GAP;
                    spi_select <= 1'b0;
                    read_n     <= 1'b1;
                end
                WR1: state <= WR2;
                WR2: begin
                    state      <= GAP;
                    spi_select <= 1'b0;
                    write_n    <= 1'b1;
                end
                ST1: state <= ST2;
                ST2: begin
                    if (roe && rx_ovf_cnt != 8'hFF) rx_ovf_cnt <= rx_ovf_cnt + 8'd1;
                    if (toe && tx_ovf_cnt != 8'hFF) tx_ovf_cnt <= tx_ovf_cnt + 8'd1;
                    if (roe || toe) begin
                        state         <= CLR1;
                        read_n        <= 1'b1;
                        write_n       <= 1'b0;
                        data_from_cpu <= 16'h0000;
                    end else begin
                        state      <= GAP;
                        spi_select <= 1'b0;
                        read_n     <= 1'b1;
                    end
                end
                CLR1: state <= CLR2;
                CLR2: begin
                    state      <= GAP;
                    spi_select <= 1'b0;
                    write_n    <= 1'b1;
                end
                GAP: state <= IDLE;
                default: begin
                    state      <= IDLE;
                    spi_select <= 1'b0;
                    read_n     <= 1'b1;
                    write_n    <= 1'b1;
                end
            endcase
        end
    end
endmodule
